regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning register index width; depth is 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning register width.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning read port count (1..4).
REQ-004 SHALL have parameter NUM_WR, default 2, meaning write port count (1..4).
REQ-005 SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding enabled.
REQ-006 SHALL have parameter ZERO_REG, default 1, meaning register 0 hardwired to zero.
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-009 SHALL have port wen, input, NUM_WR, meaning per-port write enable.
REQ-010 SHALL have port waddr, input, NUM_WR*ADDR_WIDTH, meaning packed write addresses, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port wdata, input, NUM_WR*DATA_WIDTH, meaning packed write data.
REQ-012 SHALL have port raddr, input, NUM_RD*ADDR_WIDTH, meaning packed read addresses.
REQ-013 SHALL have port rdata, output, NUM_RD*DATA_WIDTH, meaning packed read data.
REQ-014 SHALL have port rd_busy, output, NUM_RD, meaning the addressed register has a pending writeback.
REQ-015 SHALL have port alloc_en, input, 1, meaning mark a destination register busy.
REQ-016 SHALL have port alloc_addr, input, ADDR_WIDTH, meaning the register to mark busy.
REQ-017 SHALL have port wr_conflict, output, 1, meaning sticky flag for a same-cycle multi-port write to one address.

Function
REQ-018 SHALL write wdata[k] into register waddr[k] at the rising clk edge when wen[k]=1, except address 0 when ZERO_REG=1.
REQ-019 SHALL resolve two or more ports writing one address in the same cycle so that the highest port index wins.
REQ-020 SHALL produce rdata combinationally from raddr with zero-cycle read latency.
REQ-021 SHALL, with BYPASS=1, return on rdata[i] the wdata of the highest-index port writing raddr[i] in the same cycle; with BYPASS=0 it SHALL return the stored value, and the write SHALL become visible the next cycle.
REQ-022 SHALL return 0 for reads of address 0 when ZERO_REG=1, regardless of writes or bypass.
REQ-023 SHALL hold one busy bit per register; alloc_en=1 SHALL set busy[alloc_addr] at the next edge.
REQ-024 SHALL clear busy[waddr[k]] at the edge where wen[k]=1.
REQ-025 SHALL, when alloc and writeback target the same address in one cycle, let alloc win so the bit ends up set.
REQ-026 SHALL ignore alloc to address 0 when ZERO_REG=1; busy[0] SHALL stay 0.
REQ-027 SHALL drive rd_busy[i] = busy[raddr[i]], forced to 0 when BYPASS=1 and a same-cycle write targets raddr[i].
REQ-028 SHALL set wr_conflict at the edge where two enabled write ports share an address (nonzero address when ZERO_REG=1), and hold it until reset.

Reset
REQ-029 SHALL clear all registers, all busy bits and wr_conflict immediately when rst_n=0, independent of clk.
REQ-030 SHALL ignore writes and allocs while rst_n=0; with no writes in flight, rdata SHALL read 0 and rd_busy SHALL read 0 during reset.
REQ-031 SHALL resume normal operation at the first rising clk edge after rst_n deasserts; a reset mid-operation SHALL discard pending busy state.

Structure
REQ-032 SHALL place the default ADDR_WIDTH/DATA_WIDTH constants and ZERO_ADDR in the shared package regfile_pkg.
REQ-033 SHALL implement the per-address write-port priority search (hit flag, winning data) as sub-module regfile_wr_sel, instanced per read port for bypass and per register for update.

Verification
REQ-034 SHALL cover: wen=01, waddr0=3, wdata0=0xDEADBEEF, raddr0=3 same cycle -> rdata0=0xDEADBEEF (BYPASS=1), or old value 0 that cycle then 0xDEADBEEF next cycle (BYPASS=0).
REQ-035 SHALL cover: both ports write address 7 with 0x11 and 0x22 -> reg7=0x22 and wr_conflict=1, held until rst_n=0.
REQ-036 SHALL cover: write 0xFFFFFFFF to address 0 and alloc address 0 -> rdata=0 and rd_busy=0.
REQ-037 SHALL cover: alloc 5, read 5 -> rd_busy=1; alloc 5 and write 5 in the same cycle -> busy stays 1; write 5 alone -> rd_busy=0.
REQ-038 SHALL cover: after writing 0xA5 to register 9, assert rst_n=0 between edges -> rdata reads 0 immediately and all busy bits clear.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Index of the register that reads as zero when ZERO_REG is set.
  localparam int unsigned ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_wr_sel.sv
// Write-port priority search for one address: reports whether any enabled port targets
// the address and returns the data of the highest-index such port.
module regfile_wr_sel
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_WR     = 2
) (
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [NUM_WR-1:0]            wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
  output logic                         hit,
  output logic [DATA_WIDTH-1:0]        data
);

  // Ascending scan so a later (higher) port overrides an earlier match.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (wen[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
        hit  = 1'b1;
        data = wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass, hardwired zero register,
// per-register busy (scoreboard) bits and a sticky same-address write conflict flag.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2,
  parameter bit          BYPASS     = 1'b1,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_WR-1:0]            wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         alloc_en,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  output logic                         wr_conflict
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q    [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      reg_hit;
  logic [DATA_WIDTH-1:0] reg_data [DEPTH];
  logic                  conflict;
  logic                  wr_conflict_q;

  // Storage and busy bit per register.
  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    logic alloc_hit;

    if (ZERO_REG && (r == ZERO_ADDR)) begin : g_zero
      assign reg_hit[r]  = 1'b0;
      assign reg_data[r] = '0;
      assign alloc_hit   = 1'b0;
    end else begin : g_sel
      regfile_wr_sel #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_WR    (NUM_WR)
      ) u_sel (
        .addr (ADDR_WIDTH'(r)),
        .wen  (wen),
        .waddr(waddr),
        .wdata(wdata),
        .hit  (reg_hit[r]),
        .data (reg_data[r])
      );
      assign alloc_hit = alloc_en && (alloc_addr == ADDR_WIDTH'(r));
    end

    // Update the register value and its busy bit; alloc beats writeback on the busy bit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[r]  <= '0;
        busy_q[r] <= 1'b0;
      end else begin
        if (reg_hit[r]) begin
          mem_q[r] <= reg_data[r];
        end
        if (alloc_hit) begin
          busy_q[r] <= 1'b1;
        end else if (reg_hit[r]) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  // Read ports, each with its own bypass search over the write ports.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  byp_hit;
    logic [DATA_WIDTH-1:0] byp_data;
    logic                  is_zero;
    logic                  use_byp;

    assign ra      = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign is_zero = ZERO_REG && (ra == ADDR_WIDTH'(ZERO_ADDR));
    assign use_byp = BYPASS && byp_hit;

    regfile_wr_sel #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_WR    (NUM_WR)
    ) u_byp (
      .addr (ra),
      .wen  (wen),
      .waddr(waddr),
      .wdata(wdata),
      .hit  (byp_hit),
      .data (byp_data)
    );

    // Select zero, forwarded write data or stored value; a forwarded write is not busy.
    always_comb begin
      rdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      rd_busy[i]                        = 1'b0;
      if (!is_zero) begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = use_byp ? byp_data : mem_q[ra];
        rd_busy[i]                        = busy_q[ra] && !use_byp;
      end
    end
  end

  // Detect any pair of enabled write ports sharing a writable address.
  always_comb begin
    conflict = 1'b0;
    for (int unsigned a = 0; a < NUM_WR; a++) begin
      for (int unsigned b = a + 1; b < NUM_WR; b++) begin
        if (wen[a] && wen[b] &&
            (waddr[a*ADDR_WIDTH +: ADDR_WIDTH] == waddr[b*ADDR_WIDTH +: ADDR_WIDTH]) &&
            !(ZERO_REG && (waddr[a*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(ZERO_ADDR)))) begin
          conflict = 1'b1;
        end
      end
    end
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_conflict_q <= 1'b0;
    end else if (conflict) begin
      wr_conflict_q <= 1'b1;
    end
  end

  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing instance and a non-bypassing instance share
// the same stimulus; expected values are written out by hand.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic        alloc_en;
  logic [4:0]  alloc_addr;

  logic [63:0] rdata;
  logic [1:0]  rd_busy;
  logic        wr_conflict;
  logic [63:0] nb_rdata;
  logic [1:0]  nb_rd_busy;
  logic        nb_wr_conflict;

  int checks;
  int failures;

  regfile_mp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .rd_busy    (rd_busy),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .wr_conflict(wr_conflict)
  );

  regfile_mp #(
    .BYPASS(1'b0)
  ) dut_nb (
    .clk        (clk),
    .rst_n      (rst_n),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (nb_rdata),
    .rd_busy    (nb_rd_busy),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .wr_conflict(nb_wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wen        = 2'b00;
    waddr      = '0;
    wdata      = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    raddr = '0;
    rst_n = 1'b0;
    #1;
    check("reset_rdata0", rdata[31:0], 32'h0);
    check("reset_rd_busy", {30'h0, rd_busy}, 32'h0);
    check("reset_conflict", {31'h0, wr_conflict}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-port write with same-cycle read: bypass vs. stored value.
    wen = 2'b01; waddr[4:0] = 5'd3; wdata[31:0] = 32'hDEADBEEF; raddr[4:0] = 5'd3;
    #1;
    check("byp_same_cycle", rdata[31:0], 32'hDEADBEEF);
    check("nobyp_same_cycle", nb_rdata[31:0], 32'h0);
    step();
    idle();
    #1;
    check("byp_next_cycle", rdata[31:0], 32'hDEADBEEF);
    check("nobyp_next_cycle", nb_rdata[31:0], 32'hDEADBEEF);
    check("single_write_no_conflict", {31'h0, wr_conflict}, 32'h0);

    // Port 1 alone writes register 12, read back on read port 1.
    wen = 2'b10; waddr[9:5] = 5'd12; wdata[63:32] = 32'h0000_1234; raddr[9:5] = 5'd12;
    step();
    idle();
    #1;
    check("port1_write", rdata[63:32], 32'h0000_1234);

    // Both ports write register 7: port 1 wins, conflict becomes sticky.
    wen = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11}; raddr[9:5] = 5'd7;
    #1;
    check("byp_priority", rdata[63:32], 32'h22);
    step();
    idle();
    raddr[4:0] = 5'd7;
    #1;
    check("reg7_priority", rdata[31:0], 32'h22);
    check("conflict_set", {31'h0, wr_conflict}, 32'h1);
    repeat (3) step();
    check("conflict_held", {31'h0, nb_wr_conflict}, 32'h1);

    // Register 0: writes and allocs have no effect.
    wen = 2'b01; waddr[4:0] = 5'd0; wdata[31:0] = 32'hFFFFFFFF;
    alloc_en = 1'b1; alloc_addr = 5'd0; raddr[4:0] = 5'd0;
    #1;
    check("zero_byp_rdata", rdata[31:0], 32'h0);
    check("zero_byp_busy", {31'h0, rd_busy[0]}, 32'h0);
    step();
    idle();
    #1;
    check("zero_rdata", rdata[31:0], 32'h0);
    check("zero_busy", {31'h0, rd_busy[0]}, 32'h0);

    // Busy tracking on register 5.
    alloc_en = 1'b1; alloc_addr = 5'd5; raddr = {5'd5, 5'd5};
    #1;
    check("busy_before_alloc", {31'h0, rd_busy[0]}, 32'h0);
    step();
    idle();
    #1;
    check("busy_after_alloc", {30'h0, rd_busy}, 32'h3);
    alloc_en = 1'b1; alloc_addr = 5'd5; wen = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'h55;
    #1;
    check("busy_masked_by_byp", {31'h0, rd_busy[0]}, 32'h0);
    check("nobyp_busy_same_cycle", {31'h0, nb_rd_busy[0]}, 32'h1);
    step();
    idle();
    #1;
    check("alloc_wins_busy", {31'h0, rd_busy[0]}, 32'h1);
    check("alloc_wins_busy_nb", {31'h0, nb_rd_busy[1]}, 32'h1);
    check("alloc_wins_data", rdata[31:0], 32'h55);
    wen = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'h66;
    step();
    idle();
    #1;
    check("writeback_clears", {30'h0, rd_busy}, 32'h0);
    check("writeback_data", nb_rdata[31:0], 32'h66);

    // Asynchronous reset between edges.
    wen = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'hA5; alloc_en = 1'b1; alloc_addr = 5'd10;
    step();
    idle();
    raddr = {5'd10, 5'd9};
    #1;
    check("pre_reset_data", rdata[31:0], 32'hA5);
    check("pre_reset_busy", {31'h0, rd_busy[1]}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rdata", rdata[31:0], 32'h0);
    check("async_rst_busy", {30'h0, rd_busy}, 32'h0);
    check("async_rst_conflict", {31'h0, wr_conflict}, 32'h0);
    check("async_rst_nb_rdata", nb_rdata[31:0], 32'h0);

    // Writes and allocs presented during reset are dropped.
    wen = 2'b01; waddr[4:0] = 5'd4; wdata[31:0] = 32'hABC; alloc_en = 1'b1; alloc_addr = 5'd4;
    step();
    idle();
    rst_n = 1'b1;
    raddr = {5'd4, 5'd4};
    #1;
    check("rst_write_ignored", nb_rdata[31:0], 32'h0);
    check("rst_alloc_ignored", {30'h0, rd_busy}, 32'h0);

    // Normal operation resumes after reset release.
    wen = 2'b01; waddr[4:0] = 5'd4; wdata[31:0] = 32'h77;
    step();
    idle();
    #1;
    check("resume_write", nb_rdata[63:32], 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
